// File: rtl/mips_defs.sv
// Shared encodings for the load/store path: access sizes and little-endian byte lanes.
package mips_defs;

   localparam int unsigned WORD_W = 32;
   localparam int unsigned LANES  = 4;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   localparam logic [1:0] LANE0 = 2'd0;
   localparam logic [1:0] LANE1 = 2'd1;
   localparam logic [1:0] LANE2 = 2'd2;
   localparam logic [1:0] LANE3 = 2'd3;

endpackage

// File: rtl/lsu_align.sv
// Lane alignment for loads and stores: byte enables, replicated store data,
// extended load data and the raw alignment check.
module lsu_align
   import mips_defs::*;
(
   input  logic [1:0]  i_size,
   input  logic [1:0]  i_addr_lo,
   input  logic        i_unsigned_ld,
   input  logic [31:0] i_write_data,
   input  logic [31:0] i_raw_word,
   output logic [3:0]  o_byte_en,
   output logic [31:0] o_store_data,
   output logic [31:0] o_load_data,
   output logic        o_misaligned
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Byte and halfword selected from the raw word by lane
   always_comb begin
      w_byte = i_raw_word[7:0];
      unique case (i_addr_lo)
         LANE0: w_byte = i_raw_word[7:0];
         LANE1: w_byte = i_raw_word[15:8];
         LANE2: w_byte = i_raw_word[23:16];
         LANE3: w_byte = i_raw_word[31:24];
         default: w_byte = i_raw_word[7:0];
      endcase
      w_half = i_addr_lo[1] ? i_raw_word[31:16] : i_raw_word[15:0];
   end

   // Reserved size 2'b11 falls into the word branch
   always_comb begin
      o_byte_en    = 4'b0000;
      o_store_data = '0;
      o_load_data  = '0;
      o_misaligned = 1'b0;
      case (i_size)
         SZ_BYTE: begin
            o_byte_en    = 4'(4'b0001 << i_addr_lo);
            o_store_data = {4{i_write_data[7:0]}};
            o_load_data  = i_unsigned_ld ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
         end
         SZ_HALF: begin
            o_misaligned = i_addr_lo[0];
            o_byte_en    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
            o_store_data = {2{i_write_data[15:0]}};
            o_load_data  = i_unsigned_ld ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
         end
         default: begin
            o_misaligned = (i_addr_lo != 2'b00);
            o_byte_en    = 4'b1111;
            o_store_data = i_write_data;
            o_load_data  = i_raw_word;
         end
      endcase
   end

endmodule

// File: rtl/data_mem_lsu.sv
// Data memory with load/store alignment, fault detection and sticky status
// for the single-cycle datapath. Loads are combinational, stores commit on clk.
module data_mem_lsu
   import mips_defs::*;
#(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter bit          INIT_ZERO  = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_write,
   input  logic        mem_read,
   input  logic [1:0]  size,
   input  logic        unsigned_ld,
   input  logic [31:0] addr,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        misaligned,
   output logic        out_of_range,
   output logic        err_sticky,
   output logic [31:0] store_count
);

   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

   logic [WORD_W-1:0]     r_mem [DEPTH];
   logic                  r_err_sticky;
   logic [31:0]           r_store_count;

   logic [ADDR_WIDTH-1:0] w_idx;
   logic [31:0]           w_raw;
   logic                  w_access;
   logic                  w_align_bad;
   logic                  w_fault;
   logic                  w_commit;
   logic [3:0]            w_byte_en;
   logic [31:0]           w_store_data;
   logic [31:0]           w_load_data;

   assign w_idx    = addr[ADDR_WIDTH+1:2];
   assign w_raw    = r_mem[w_idx];
   assign w_access = mem_read | mem_write;

   lsu_align u_align (
      .i_size        (size),
      .i_addr_lo     (addr[1:0]),
      .i_unsigned_ld (unsigned_ld),
      .i_write_data  (write_data),
      .i_raw_word    (w_raw),
      .o_byte_en     (w_byte_en),
      .o_store_data  (w_store_data),
      .o_load_data   (w_load_data),
      .o_misaligned  (w_align_bad)
   );

   // Fault flags and load result are held at zero while reset is high
   assign misaligned   = ~reset & w_access & w_align_bad;
   assign out_of_range = ~reset & w_access & (addr[31:ADDR_WIDTH+2] != '0);
   assign w_fault      = misaligned | out_of_range;
   assign w_commit     = ~reset & mem_write & ~w_fault;
   assign read_data    = (~reset & mem_read & ~w_fault) ? w_load_data : 32'd0;

   // Memory array: optional clear on reset, lane-masked write on commit
   always_ff @(posedge clk) begin
      if (reset && INIT_ZERO) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_commit) begin
         for (int unsigned b = 0; b < LANES; b++) begin
            if (w_byte_en[b]) begin
               r_mem[w_idx][8*b +: 8] <= w_store_data[8*b +: 8];
            end
         end
      end
   end

   // Status registers
   always_ff @(posedge clk) begin
      if (reset) begin
         r_err_sticky  <= 1'b0;
         r_store_count <= 32'd0;
      end else begin
         if (w_fault) begin
            r_err_sticky <= 1'b1;
         end
         if (w_commit) begin
            r_store_count <= r_store_count + 32'd1;
         end
      end
   end

   assign err_sticky  = r_err_sticky;
   assign store_count = r_store_count;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Self-checking bench for data_mem_lsu: directed vector table, hand-written
// reset/same-word sequences, then random traffic against a byte-level model.
module tb_data_mem_lsu;

   logic        clk;
   logic        reset;
   logic        mem_write;
   logic        mem_read;
   logic [1:0]  size;
   logic        unsigned_ld;
   logic [31:0] addr;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic        misaligned;
   logic        out_of_range;
   logic        err_sticky;
   logic [31:0] store_count;

   int n_checks = 0;
   int n_errors = 0;

   data_mem_lsu #(.ADDR_WIDTH(8), .INIT_ZERO(1'b1)) dut (
      .clk          (clk),
      .reset        (reset),
      .mem_write    (mem_write),
      .mem_read     (mem_read),
      .size         (size),
      .unsigned_ld  (unsigned_ld),
      .addr         (addr),
      .write_data   (write_data),
      .read_data    (read_data),
      .misaligned   (misaligned),
      .out_of_range (out_of_range),
      .err_sticky   (err_sticky),
      .store_count  (store_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        wr;
      logic        rd;
      logic [1:0]  sz;
      logic        uns;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] exp_rd;
      logic        exp_mis;
      logic        exp_oor;
      logic        exp_err;
      logic [31:0] exp_cnt;
   } vec_t;

   vec_t tbl[$];

   // Reference model: 1 KiB as plain bytes plus status
   logic [7:0]  m_mem [1024];
   logic        m_err;
   logic [31:0] m_cnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic wr, input logic rd, input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic [31:0] wd, input logic [31:0] e_rd,
                      input logic e_mis, input logic e_oor, input logic e_err,
                      input logic [31:0] e_cnt);
      vec_t v;
      v.wr = wr; v.rd = rd; v.sz = sz; v.uns = uns; v.a = a; v.wd = wd;
      v.exp_rd = e_rd; v.exp_mis = e_mis; v.exp_oor = e_oor; v.exp_err = e_err; v.exp_cnt = e_cnt;
      tbl.push_back(v);
   endtask

   // Drive one access at negedge, check combinational outputs before the edge,
   // then check status after the edge.
   task automatic apply(input string tag, input vec_t v);
      @(negedge clk);
      mem_write = v.wr; mem_read = v.rd; size = v.sz; unsigned_ld = v.uns;
      addr = v.a; write_data = v.wd;
      #1;
      chk({tag, " read_data"}, read_data, v.exp_rd);
      chk({tag, " misaligned"}, 32'(misaligned), 32'(v.exp_mis));
      chk({tag, " out_of_range"}, 32'(out_of_range), 32'(v.exp_oor));
      @(posedge clk);
      #1;
      chk({tag, " err_sticky"}, 32'(err_sticky), 32'(v.exp_err));
      chk({tag, " store_count"}, store_count, v.exp_cnt);
   endtask

   function automatic int nbytes(input logic [1:0] sz);
      if (sz == 2'b00) return 1;
      if (sz == 2'b01) return 2;
      return 4;
   endfunction

   // Expected behaviour from the byte-level model; also advances the model
   function automatic vec_t model_step(input logic wr, input logic rd, input logic [1:0] sz,
                                       input logic uns, input logic [31:0] a, input logic [31:0] wd);
      vec_t v;
      int n;
      logic [31:0] val;
      logic fault;
      v.wr = wr; v.rd = rd; v.sz = sz; v.uns = uns; v.a = a; v.wd = wd;
      n = nbytes(sz);
      v.exp_oor = (wr || rd) && ((a / 1024) != 0);
      v.exp_mis = (wr || rd) && ((a % n) != 0);
      fault = v.exp_oor || v.exp_mis;
      val = 0;
      if (rd && !fault) begin
         for (int i = 0; i < n; i++) val = val | (32'(m_mem[a + i]) << (8 * i));
         if (n < 4 && !uns && val[8*n-1]) val = val | (32'hFFFF_FFFF << (8 * n));
      end
      v.exp_rd = val;
      if (fault) m_err = 1'b1;
      else if (wr) begin
         for (int i = 0; i < n; i++) m_mem[a + i] = 8'((wd >> (8 * i)) & 32'hFF);
         m_cnt = m_cnt + 32'd1;
      end
      v.exp_err = m_err;
      v.exp_cnt = m_cnt;
      return v;
   endfunction

   task automatic do_reset(input logic wr_during);
      @(negedge clk);
      reset = 1'b1; mem_write = wr_during; mem_read = 1'b1; size = 2'b10; unsigned_ld = 1'b0;
      addr = 32'h50; write_data = 32'h1111_1111;
      #1;
      chk("reset read_data", read_data, 32'd0);
      chk("reset misaligned", 32'(misaligned), 32'd0);
      chk("reset out_of_range", 32'(out_of_range), 32'd0);
      @(posedge clk);
      #1;
      chk("reset err_sticky", 32'(err_sticky), 32'd0);
      chk("reset store_count", store_count, 32'd0);
      @(negedge clk);
      reset = 1'b0; mem_write = 1'b0; mem_read = 1'b0;
      for (int i = 0; i < 1024; i++) m_mem[i] = 8'd0;
      m_err = 1'b0;
      m_cnt = 32'd0;
   endtask

   initial begin
      vec_t v;
      reset = 1'b1; mem_write = 1'b0; mem_read = 1'b0; size = 2'b10;
      unsigned_ld = 1'b0; addr = 32'd0; write_data = 32'd0;
      repeat (2) @(posedge clk);
      do_reset(1'b0);

      //   wr rd sz    u  addr     wdata          exp_rd         mis oor err cnt
      add(0, 1, 2'd2, 0, 32'h000, 32'h0,         32'h0,         0, 0, 0, 0);
      add(0, 1, 2'd2, 0, 32'h3FC, 32'h0,         32'h0,         0, 0, 0, 0);
      add(1, 0, 2'd2, 0, 32'h010, 32'h12345678,  32'h0,         0, 0, 0, 1);
      add(0, 1, 2'd2, 0, 32'h010, 32'h0,         32'h12345678,  0, 0, 0, 1);
      add(0, 1, 2'd0, 0, 32'h013, 32'h0,         32'h00000012,  0, 0, 0, 1);
      add(0, 1, 2'd1, 0, 32'h010, 32'h0,         32'h00005678,  0, 0, 0, 1);
      add(1, 0, 2'd2, 0, 32'h020, 32'hFFFFFFFF,  32'h0,         0, 0, 0, 2);
      add(1, 0, 2'd0, 0, 32'h021, 32'h000000AB,  32'h0,         0, 0, 0, 3);
      add(0, 1, 2'd2, 0, 32'h020, 32'h0,         32'hFFFFABFF,  0, 0, 0, 3);
      add(0, 1, 2'd0, 0, 32'h021, 32'h0,         32'hFFFFFFAB,  0, 0, 0, 3);
      add(0, 1, 2'd0, 1, 32'h021, 32'h0,         32'h000000AB,  0, 0, 0, 3);
      add(1, 0, 2'd1, 0, 32'h032, 32'h00008001,  32'h0,         0, 0, 0, 4);
      add(0, 1, 2'd2, 0, 32'h030, 32'h0,         32'h80010000,  0, 0, 0, 4);
      add(0, 1, 2'd1, 0, 32'h032, 32'h0,         32'hFFFF8001,  0, 0, 0, 4);
      add(0, 1, 2'd1, 1, 32'h032, 32'h0,         32'h00008001,  0, 0, 0, 4);
      add(0, 1, 2'd3, 0, 32'h010, 32'h0,         32'h12345678,  0, 0, 0, 4);
      add(0, 0, 2'd2, 0, 32'h013, 32'h0,         32'h0,         0, 0, 0, 4);
      add(1, 0, 2'd2, 0, 32'h006, 32'hDEADBEEF,  32'h0,         1, 0, 1, 4);
      add(0, 1, 2'd2, 0, 32'h004, 32'h0,         32'h0,         0, 0, 1, 4);
      add(1, 0, 2'd2, 0, 32'h400, 32'hDEADBEEF,  32'h0,         0, 1, 1, 4);
      add(0, 1, 2'd2, 0, 32'h000, 32'h0,         32'h0,         0, 0, 1, 4);
      add(0, 1, 2'd2, 0, 32'h011, 32'h0,         32'h0,         1, 0, 1, 4);
      add(0, 1, 2'd1, 0, 32'h013, 32'h0,         32'h0,         1, 0, 1, 4);
      add(1, 1, 2'd2, 0, 32'h040, 32'hCAFEF00D,  32'h0,         0, 0, 1, 5);
      add(0, 1, 2'd2, 0, 32'h040, 32'h0,         32'hCAFEF00D,  0, 0, 1, 5);

      foreach (tbl[i]) apply($sformatf("vec%0d", i), tbl[i]);

      // Reset concurrent with a store: no write, counters cleared, memory cleared
      do_reset(1'b1);
      v = model_step(1'b0, 1'b1, 2'd2, 1'b0, 32'h50, 32'h0);
      apply("post-reset 0x50", v);
      v = model_step(1'b0, 1'b1, 2'd2, 1'b0, 32'h10, 32'h0);
      apply("post-reset 0x10", v);

      // Same-word read and write in one cycle, through the model
      v = model_step(1'b1, 1'b1, 2'd2, 1'b0, 32'h44, 32'hA5A5_5A5A);
      apply("rw same word", v);
      v = model_step(1'b0, 1'b1, 2'd1, 1'b0, 32'h46, 32'h0);
      apply("rw next cycle", v);

      // Random traffic against the model
      for (int k = 0; k < 400; k++) begin
         logic [31:0] ra;
         int sel;
         sel = $urandom_range(0, 15);
         ra = (sel == 0) ? $urandom : 32'($urandom_range(0, 127));
         v = model_step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), ra, $urandom);
         apply($sformatf("rand%0d", k), v);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
